// File: rtl/bitcell_ctrl_pkg.sv
// rtl/bitcell_ctrl_pkg.sv - shared FSM states, phase lengths and read-bus sampling helper
package bitcell_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_PULSE,
      S_HOLD,
      S_RESP,
      S_VSETUP,
      S_VPULSE
   } state_t;

   localparam int SETUP_CYCLES = 1;
   localparam int HOLD_CYCLES  = 1;

   // Returns {unknown, value}: unknown flags X/Z, value is 1 only for a clean 1.
   function automatic logic [1:0] sample_bit(input logic b);
      return {(b !== 1'b0) && (b !== 1'b1), b === 1'b1};
   endfunction

endpackage

// File: rtl/bitcell_row_decoder.sv
// rtl/bitcell_row_decoder.sv - registered one-hot row select with enable and range check
module bitcell_row_decoder #(
   parameter int ROWS   = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [ADDR_W-1:0] addr,
   output logic [ROWS-1:0]   sel,
   output logic              in_range
);

   logic [ROWS-1:0] dec;

   // An address with no matching row decodes to all-zero, which doubles as the range check.
   always_comb begin
      dec = '0;
      for (int r = 0; r < ROWS; r++) begin
         dec[r] = (addr == ADDR_W'(r));
      end
   end

   assign in_range = |dec;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel <= '0;
      end else begin
         sel <= en ? dec : '0;
      end
   end

endmodule

// File: rtl/bitcell_array_ctrl.sv
// rtl/bitcell_array_ctrl.sv - word access sequencer for a row-organised NAND-latch bitcell array
// Optional write read-back verify: define BITCELL_CTRL_VERIFY_EN.
module bitcell_array_ctrl
   import bitcell_ctrl_pkg::*;
#(
   parameter  int WIDTH    = 8,
   parameter  int ROWS     = 16,
   parameter  int WR_PULSE = 2,
   parameter  int RD_PULSE = 1,
   localparam int ADDR_W   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [WIDTH-1:0]  req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [WIDTH-1:0]  rsp_rdata,
   output logic              rsp_err,
   output logic [ROWS-1:0]   arr_sel,
   output logic              arr_rw,
   output logic [WIDTH-1:0]  arr_din,
   input  logic [WIDTH-1:0]  arr_dout
);

   localparam int PMAX = (WR_PULSE > RD_PULSE) ? WR_PULSE : RD_PULSE;
   localparam int CW   = $clog2(PMAX + 1);

   state_t            state, state_nx;
   logic [CW-1:0]     cnt;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [WIDTH-1:0]  samp_q;
   logic              samp_err_q;
   logic              in_range;
   logic              accept;
   logic              phase_done;
   logic [WIDTH-1:0]  samp_clean;
   logic [WIDTH-1:0]  samp_xz;
`ifdef BITCELL_CTRL_VERIFY_EN
   logic [WIDTH-1:0]  wdata_q;
   logic              vfy_q;
`endif

   assign accept     = (state == S_IDLE) && req_valid && req_ready;
   assign phase_done = (cnt == '0);

   always_comb begin
      samp_clean = '0;
      samp_xz    = '0;
      for (int i = 0; i < WIDTH; i++) begin
         {samp_xz[i], samp_clean[i]} = sample_bit(arr_dout[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (accept) state_nx = S_SETUP;
         S_SETUP:  if (phase_done) state_nx = S_PULSE;
         S_PULSE:  if (phase_done) state_nx = S_HOLD;
         S_HOLD: begin
            if (phase_done) begin
`ifdef BITCELL_CTRL_VERIFY_EN
               state_nx = (we_q && !vfy_q) ? S_VSETUP : S_RESP;
`else
               state_nx = S_RESP;
`endif
            end
         end
         S_RESP:   if (rsp_ready) state_nx = S_IDLE;
`ifdef BITCELL_CTRL_VERIFY_EN
         S_VSETUP: if (phase_done) state_nx = S_VPULSE;
         S_VPULSE: if (phase_done) state_nx = S_HOLD;
`endif
         default:  state_nx = S_IDLE;
      endcase
   end

   bitcell_row_decoder #(
      .ROWS   (ROWS),
      .ADDR_W (ADDR_W)
   ) u_dec (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       ((state_nx == S_PULSE) || (state_nx == S_VPULSE)),
      .addr     (addr_q),
      .sel      (arr_sel),
      .in_range (in_range)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         samp_q     <= '0;
         samp_err_q <= 1'b0;
         req_ready  <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
         arr_rw     <= 1'b0;
         arr_din    <= '0;
      end else begin
         req_ready <= (state_nx == S_IDLE);

         // The counter is reloaded on every phase change and counts down to zero within it.
         if (state_nx != state) begin
            case (state_nx)
               S_SETUP, S_VSETUP: cnt <= CW'(SETUP_CYCLES - 1);
               S_PULSE:           cnt <= we_q ? CW'(WR_PULSE - 1) : CW'(RD_PULSE - 1);
               S_VPULSE:          cnt <= CW'(RD_PULSE - 1);
               S_HOLD:            cnt <= CW'(HOLD_CYCLES - 1);
               default:           cnt <= '0;
            endcase
         end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
         end

         if (accept) begin
            we_q       <= req_we;
            addr_q     <= req_addr;
            samp_q     <= '0;
            samp_err_q <= 1'b0;
            arr_rw     <= req_we;
            arr_din    <= req_we ? req_wdata : '0;
         end

         if ((state == S_PULSE) && phase_done && !we_q) begin
            samp_q     <= samp_clean;
            samp_err_q <= |samp_xz;
         end

`ifdef BITCELL_CTRL_VERIFY_EN
         if ((state_nx == S_VSETUP) && (state != S_VSETUP)) begin
            arr_rw <= 1'b0;
         end
         if ((state == S_VPULSE) && phase_done) begin
            samp_q     <= samp_clean;
            samp_err_q <= (|samp_xz) || (samp_clean != wdata_q);
         end
`endif

         if ((state == S_HOLD) && (state_nx == S_RESP)) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= (we_q || !in_range) ? '0 : samp_q;
            rsp_err   <= !in_range || samp_err_q;
            arr_rw    <= 1'b0;
            arr_din   <= '0;
         end

         if ((state == S_RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
         end
      end
   end

`ifdef BITCELL_CTRL_VERIFY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdata_q <= '0;
         vfy_q   <= 1'b0;
      end else if (accept) begin
         wdata_q <= req_wdata;
         vfy_q   <= 1'b0;
      end else if ((state_nx == S_VSETUP) && (state != S_VSETUP)) begin
         vfy_q <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_bitcell_array_ctrl.sv
// tb/tb_bitcell_array_ctrl.sv - self-checking bench for bitcell_array_ctrl with a cell array model
module tb_bitcell_array_ctrl;

   localparam int WIDTH    = 8;
   localparam int ROWS     = 16;
   localparam int WR_PULSE = 2;
   localparam int RD_PULSE = 1;
`ifdef BITCELL_CTRL_VERIFY_EN
   localparam int LAT_W     = WR_PULSE + RD_PULSE + 5;
   localparam int NP_W      = 2;
   localparam int STUCK_ERR = 1;
`else
   localparam int LAT_W     = WR_PULSE + 3;
   localparam int NP_W      = 1;
   localparam int STUCK_ERR = 0;
`endif
   localparam int LAT_R = RD_PULSE + 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic             req_we = 1'b0;
   logic [3:0]       req_addr = '0;
   logic [WIDTH-1:0] req_wdata = '0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b1;
   logic [WIDTH-1:0] rsp_rdata;
   logic             rsp_err;
   logic [ROWS-1:0]  arr_sel;
   logic             arr_rw;
   logic [WIDTH-1:0] arr_din;
   wire  [WIDTH-1:0] arr_dout;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bitcell_array_ctrl #(
      .WIDTH(WIDTH), .ROWS(ROWS), .WR_PULSE(WR_PULSE), .RD_PULSE(RD_PULSE)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .arr_sel(arr_sel), .arr_rw(arr_rw), .arr_din(arr_din), .arr_dout(arr_dout)
   );

   // Cell array: a selected, previously written row drives the bus on read; otherwise it floats.
   logic [WIDTH-1:0] cell_mem [ROWS];
   logic             cell_wr  [ROWS];
   logic [WIDTH-1:0] stuck0 = '0;
   logic             bus_en;
   logic [WIDTH-1:0] bus_data;

   always_comb begin
      bus_en   = 1'b0;
      bus_data = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (arr_sel[r] && !arr_rw && cell_wr[r]) begin
            bus_en   = 1'b1;
            bus_data = cell_mem[r] & ~stuck0;
         end
      end
   end
   assign arr_dout = bus_en ? bus_data : 'z;

   // Detects whether this simulator keeps Z distinct from 0.
   logic probe_en = 1'b0;
   wire  probe_w;
   assign probe_w = probe_en ? 1'b1 : 1'bz;
   logic four_state = 1'b0;

   // Monitor: cell writes, select pulse lengths and the strobe/data stability rule.
   int              run_len = 0;
   logic [ROWS-1:0] run_sel;
   int              viol = 0;
   int              pulse_len_q[$];
   logic [ROWS-1:0] pulse_sel_q[$];
   logic            prev_rw;
   logic [WIDTH-1:0] prev_din;
   logic [ROWS-1:0] prev_sel;

   initial begin
      for (int r = 0; r < ROWS; r++) begin
         cell_mem[r] = '0;
         cell_wr[r]  = 1'b0;
      end
      prev_rw = 1'b0; prev_din = '0; prev_sel = '0; run_sel = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            run_len = 0;
         end else begin
            if ((arr_sel != '0 || prev_sel != '0) && (arr_rw != prev_rw || arr_din != prev_din))
               viol++;
            if (arr_sel != '0) begin
               if (!$onehot(arr_sel) || (run_len != 0 && arr_sel != run_sel)) viol++;
               if (run_len == 0) run_sel = arr_sel;
               run_len++;
               for (int r = 0; r < ROWS; r++) begin
                  if (arr_sel[r] && arr_rw) begin
                     cell_mem[r] = arr_din;
                     cell_wr[r]  = 1'b1;
                  end
               end
            end else if (run_len != 0) begin
               pulse_len_q.push_back(run_len);
               pulse_sel_q.push_back(run_sel);
               run_len = 0;
            end
         end
         prev_rw = arr_rw; prev_din = arr_din; prev_sel = arr_sel;
      end
   end

   // Reference model: array contents as implied by completed requests.
   logic [WIDTH-1:0] ref_mem [ROWS];
   logic             ref_wr  [ROWS];

   task automatic ref_apply(input logic we, input logic [3:0] addr, input logic [WIDTH-1:0] wdata,
                            output logic [WIDTH-1:0] exp_rdata, output logic exp_err);
      if (we) begin
         ref_mem[addr] = wdata;
         ref_wr[addr]  = 1'b1;
         exp_rdata = '0;
         exp_err   = 1'b0;
      end else begin
         exp_rdata = ref_wr[addr] ? ref_mem[addr] : '0;
         exp_err   = ref_wr[addr] ? 1'b0 : four_state;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_req(input logic we, input logic [3:0] addr, input logic [WIDTH-1:0] wdata,
                         output logic [WIDTH-1:0] rdata, output logic err, output int lat);
      int n;
      pulse_len_q.delete();
      pulse_sel_q.delete();
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; rsp_ready = 1'b1;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("accept_timeout", 32'(n >= 50), 32'd0);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      check("rsp_timeout", 32'(lat >= 60), 32'd0);
      rdata = rsp_rdata;
      err   = rsp_err;
      @(negedge clk);
   endtask

   task automatic run_and_check(input string tag, input logic we, input logic [3:0] addr,
                                input logic [WIDTH-1:0] wdata, input logic [WIDTH-1:0] exp_rdata,
                                input logic exp_err);
      logic [WIDTH-1:0] rd;
      logic             er;
      int               lat;
      do_req(we, addr, wdata, rd, er, lat);
      check({tag, "_rdata"}, 32'(rd), 32'(exp_rdata));
      check({tag, "_err"}, 32'(er), 32'(exp_err));
      check({tag, "_latency"}, lat, we ? LAT_W : LAT_R);
      check({tag, "_npulse"}, pulse_len_q.size(), we ? NP_W : 1);
      if (pulse_len_q.size() > 0) begin
         check({tag, "_pulse_len"}, pulse_len_q[0], we ? WR_PULSE : RD_PULSE);
         check({tag, "_sel"}, 32'(pulse_sel_q[0]), 32'(16'h1 << addr));
      end
      check({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
   endtask

   typedef struct {
      logic             we;
      logic [3:0]       addr;
      logic [WIDTH-1:0] wdata;
      logic [WIDTH-1:0] exp_rdata;
      logic             exp_err;
   } vec_t;

   vec_t vecs[5];

   initial begin
      logic [WIDTH-1:0] er_d;
      logic             er_e;
      logic [3:0]       a;
      logic [WIDTH-1:0] d;
      logic             w;
      int               n;
      logic             saw;

      vecs[0] = '{1'b1, 4'd3,  8'hA5, 8'h00, 1'b0};
      vecs[1] = '{1'b0, 4'd3,  8'h00, 8'hA5, 1'b0};
      vecs[2] = '{1'b1, 4'd15, 8'h00, 8'h00, 1'b0};
      vecs[3] = '{1'b1, 4'd15, 8'hFF, 8'h00, 1'b0};
      vecs[4] = '{1'b0, 4'd15, 8'h00, 8'hFF, 1'b0};
      for (int r = 0; r < ROWS; r++) begin
         ref_mem[r] = '0;
         ref_wr[r]  = 1'b0;
      end
      #1 four_state = $isunknown(probe_w);

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      check("rst_arr_sel", 32'(arr_sel), 32'd0);
      check("rst_arr_rw", 32'(arr_rw), 32'd0);
      check("rst_arr_din", 32'(arr_din), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_req_ready", 32'(req_ready), 32'd1);

      // Directed table
      for (int i = 0; i < 5; i++) begin
         ref_apply(vecs[i].we, vecs[i].addr, vecs[i].wdata, er_d, er_e);
         check($sformatf("vec%0d_model", i), 32'(er_d), 32'(vecs[i].exp_rdata));
         run_and_check($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                       vecs[i].exp_rdata, vecs[i].exp_err);
      end

      // Never-written row with a floating bus
      ref_apply(1'b0, 4'd7, 8'h00, er_d, er_e);
      run_and_check("zread", 1'b0, 4'd7, 8'h00, 8'h00, four_state);

      // Randomized traffic against the reference model
      for (int i = 0; i < 40; i++) begin
         w = 1'($urandom_range(0, 1));
         a = 4'($urandom_range(0, ROWS - 1));
         d = 8'($urandom);
         ref_apply(w, a, d, er_d, er_e);
         run_and_check($sformatf("rand%0d", i), w, a, d, er_d, er_e);
      end

      // Response back-pressure; a request arriving meanwhile must be ignored
      pulse_len_q.delete();
      pulse_sel_q.delete();
      ref_apply(1'b0, 4'd3, 8'h00, er_d, er_e);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3; rsp_ready = 1'b0;
      @(negedge clk);
      req_we = 1'b1; req_addr = 4'd5; req_wdata = 8'h11;
      n = 0;
      while (!rsp_valid && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("stall_timeout", 32'(n >= 60), 32'd0);
      check("stall_rdata", 32'(rsp_rdata), 32'(er_d));
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
         check("stall_req_ready", 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("stall_release_valid", 32'(rsp_valid), 32'd0);
      check("stall_release_ready", 32'(req_ready), 32'd1);
      check("stall_one_pulse", pulse_len_q.size(), 1);

      // Write with bit 2 of the read bus stuck low
      stuck0 = 8'h04;
      run_and_check("stuck_write", 1'b1, 4'd2, 8'h04, 8'h00, 1'(STUCK_ERR));
      stuck0 = 8'h00;

      // Reset during the write select pulse
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd9; req_wdata = 8'h3C; rsp_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (arr_sel == '0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("abort_pulse_timeout", 32'(n >= 20), 32'd0);
      #1 rst_n = 1'b0;
      #1;
      check("abort_sel_drop", 32'(arr_sel), 32'd0);
      check("abort_req_ready", 32'(req_ready), 32'd0);
      check("abort_rw", 32'(arr_rw), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      saw = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (rsp_valid) saw = 1'b1;
      end
      check("abort_no_rsp", 32'(saw), 32'd0);
      ref_apply(1'b1, 4'd1, 8'h5A, er_d, er_e);
      run_and_check("recover_wr", 1'b1, 4'd1, 8'h5A, er_d, er_e);
      ref_apply(1'b0, 4'd1, 8'h00, er_d, er_e);
      run_and_check("recover_rd", 1'b0, 4'd1, 8'h00, 8'h5A, 1'b0);

      check("rw_din_stable_while_selected", viol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: summary not reached within 200000 time units");
      $fatal(1);
   end

endmodule
